keypad_encoder: RTL

Scans a 4-row × 5-column calculator keypad, debounces the single pressed key and emits one `valid_input` pulse per press with a 5-bit key code. Sits directly upstream of the calculator datapath: `valid_input`/`input_value` connect straight to its inputs. Codes are 0x00–0x0F for hex digits and 0x10/0x11/0x12/0x13 for plus/minus/equal/clear.

---
 rtl/calc_pkg.sv | 41 ++++
 rtl/key_sync.sv | 24 ++
 rtl/keypad_encoder.sv | 104 ++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, keypad FSM states
// and small helpers for decoding the keypad column pattern.
package calc_pkg;

    localparam logic [4:0] KEY_PLUS  = 5'h10;
    localparam logic [4:0] KEY_MINUS = 5'h11;
    localparam logic [4:0] KEY_EQUAL = 5'h12;
    localparam logic [4:0] KEY_CLEAR = 5'h13;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HOLD,
        RELEASE
    } kp_state_t;

    // True when exactly one active-low column is asserted.
    function automatic logic one_low(input logic [4:0] cols);
        logic [4:0] act;
        act = ~cols;
        return (act != 5'd0) && ((act & (act - 5'd1)) == 5'd0);
    endfunction

    function automatic logic [2:0] col_index(input logic [4:0] cols);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (!cols[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [4:0] key_code(
        input logic [1:0] row,
        input logic [2:0] col
    );
        if (col == 3'd4) return KEY_PLUS + {3'b000, row};
        return {1'b0, row, col[1:0]};
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for asynchronous inputs.
// Resets to all-ones so idle pulled-up lines read as released.
module key_sync #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// 4x5 keypad scanner with press/release debouncing.
// Emits one valid_input strobe and key code per key press.
module keypad_encoder
    import calc_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] col_n,
    output logic [3:0] row_n,
    output logic       valid_input,
    output logic [4:0] input_value,
    output logic       key_down
);

    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int BW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

    logic [4:0]    cs;
    kp_state_t     state;
    logic [1:0]    row;
    logic [DW-1:0] dwell;
    logic [BW-1:0] deb;
    logic [4:0]    pat;

    key_sync #(.WIDTH(5)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (col_n),
        .q   (cs)
    );

    assign row_n = ~(4'b0001 << row);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SCAN;
            row         <= 2'd0;
            dwell       <= '0;
            deb         <= '0;
            pat         <= 5'h1f;
            valid_input <= 1'b0;
            input_value <= 5'h00;
            key_down    <= 1'b0;
        end else begin
            valid_input <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (one_low(cs)) begin
                            pat   <= cs;
                            deb   <= '0;
                            state <= DEBOUNCE;
                        end else begin
                            row <= row + 2'd1;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (cs != pat) begin
                        row   <= row + 2'd1;
                        dwell <= '0;
                        state <= SCAN;
                    end else if (deb == DEB_LAST) begin
                        valid_input <= 1'b1;
                        input_value <= key_code(row, col_index(pat));
                        key_down    <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        deb <= deb + 1'b1;
                    end
                end
                HOLD: begin
                    // Row stays frozen, so other rows cannot be seen here.
                    if (cs == 5'h1f) begin
                        deb   <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (cs != 5'h1f) begin
                        state <= HOLD;
                    end else if (deb == DEB_LAST) begin
                        key_down <= 1'b0;
                        row      <= row + 2'd1;
                        dwell    <= '0;
                        state    <= SCAN;
                    end else begin
                        deb <= deb + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule
